// File: rtl/ghost_render.sv
// Ghost sprite renderer: two-stage ROM lookup pipeline plus the frightened/blink
// colour state machine, timed in frames.
module ghost_render #(
  parameter int unsigned SPRITE_SIZE   = 32,
  parameter int unsigned FRIGHT_FRAMES = 360,
  parameter int unsigned BLINK_FRAMES  = 96
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  GhostX,
  input  logic [9:0]  GhostY,
  input  logic        frighten,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        ghost_on,
  output logic [1:0]  ghost_color,
  output logic        fright_active
);

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COL_W   = 5;
  localparam int unsigned CNT_W   = 9;

  localparam logic [COORD_W-1:0] SIZE_C   = COORD_W'(SPRITE_SIZE);
  localparam logic [COL_W-1:0]   COL_MAX  = COL_W'(SPRITE_SIZE - 1);
  localparam logic [CNT_W-1:0]   FRIGHT_C = CNT_W'(FRIGHT_FRAMES);
  localparam logic [CNT_W-1:0]   BLINK_C  = CNT_W'(BLINK_FRAMES);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FRIGHT = 2'd1,
    BLINK  = 2'd2
  } state_t;

  // Stage 0: sprite-relative offsets; wrap makes above/left of sprite fail the test
  logic [COORD_W-1:0] dy;
  logic [COORD_W-1:0] dx;
  logic               in_y;
  logic               in_x;

  assign dy   = DrawY - GhostY;
  assign dx   = DrawX - GhostX;
  assign in_y = (dy < SIZE_C);
  assign in_x = (dx < SIZE_C);

  logic [COL_W-1:0] col;
  logic             hit1;

  // Stage 1: ROM address, column and hit flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      col      <= '0;
      hit1     <= 1'b0;
    end else begin
      rom_addr <= {3'b000, dy[COL_W-1:0]};
      col      <= dx[COL_W-1:0];
      hit1     <= in_x & in_y;
    end
  end

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] fcnt;
  logic [CNT_W-1:0] fcnt_next;
  logic [CNT_W-1:0] fcnt_dec;
  logic [1:0]       color_now;

  assign fcnt_dec = fcnt - CNT_W'(1);

  // Stage 2: pixel bit select; colour sampled from the live FSM state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ghost_on      <= 1'b0;
      ghost_color   <= 2'b00;
      fright_active <= 1'b0;
    end else begin
      ghost_on      <= hit1 & rom_data[COL_MAX - col];
      ghost_color   <= color_now;
      fright_active <= (state_next != NORMAL);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= NORMAL;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
    end
  end

  // Next state: a frighten pulse reloads and overrides any same-cycle frame tick
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    color_now  = 2'b00;
    if (frighten) begin
      state_next = FRIGHT;
      fcnt_next  = FRIGHT_C;
    end else begin
      unique case (state)
        FRIGHT: begin
          if (frame_start) begin
            fcnt_next = fcnt_dec;
            if (fcnt_dec <= BLINK_C) state_next = BLINK;
          end
        end
        BLINK: begin
          if (frame_start) begin
            fcnt_next = fcnt_dec;
            if (fcnt_dec == '0) state_next = NORMAL;
          end
        end
        NORMAL: fcnt_next = '0;
        default: begin
          state_next = NORMAL;
          fcnt_next  = '0;
        end
      endcase
    end
    unique case (state)
      FRIGHT:  color_now = 2'b01;
      BLINK:   color_now = fcnt[3] ? 2'b10 : 2'b01;
      default: color_now = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_ghost_render.sv
// Self-checking bench for ghost_render: fixed vector table, directed fright
// sequences and randomized traffic against a frame-count reference model.
module tb_ghost_render;

  localparam int SZ = 32;
  localparam int FR = 360;
  localparam int BL = 96;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        frighten;
  logic [9:0]  DrawX, DrawY, GhostX, GhostY;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        ghost_on;
  logic [1:0]  ghost_color;
  logic        fright_active;

  logic [31:0] rom_mem [32];
  logic        rom_ovr_en;
  logic [31:0] rom_ovr;

  always #5 Clk = ~Clk;

  always_comb rom_data = rom_ovr_en ? rom_ovr : rom_mem[rom_addr[4:0]];

  ghost_render #(.SPRITE_SIZE(32), .FRIGHT_FRAMES(360), .BLINK_FRAMES(96)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .GhostX(GhostX), .GhostY(GhostY),
    .frighten(frighten), .rom_addr(rom_addr), .rom_data(rom_data),
    .ghost_on(ghost_on), .ghost_color(ghost_color), .fright_active(fright_active)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: frames remaining, plus the pixel pipeline contents
  int m_rem = 0;
  int m_addr = 0;
  int m_col = 0;
  bit m_hit1 = 0;
  bit m_on = 0;
  int m_color = 0;
  bit m_fa = 0;

  typedef struct {
    logic [9:0]  gx, gy, dx, dy;
    logic [31:0] rom;
    logic [7:0]  addr;
    logic        on;
  } vec_t;

  vec_t tbl[10];

  function automatic int model_color(int rem);
    if (rem == 0) return 0;
    if (rem > BL) return 1;
    return ((rem / 8) % 2 == 1) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    int ddx, ddy, c_pre;
    bit hit, bitv;
    logic [31:0] row;
    ddx   = (int'(DrawX) - int'(GhostX) + 1024) % 1024;
    ddy   = (int'(DrawY) - int'(GhostY) + 1024) % 1024;
    hit   = (ddx < SZ) && (ddy < SZ);
    row   = rom_ovr_en ? rom_ovr : rom_mem[m_addr];
    bitv  = row[31 - m_col];
    c_pre = model_color(m_rem);
    @(posedge Clk);
    #1;
    if (Reset) begin
      m_on = 0; m_hit1 = 0; m_col = 0; m_addr = 0;
      m_color = 0; m_rem = 0; m_fa = 0;
    end else begin
      m_on    = m_hit1 && bitv;
      m_hit1  = hit;
      m_col   = ddx % 32;
      m_addr  = ddy % 32;
      m_color = c_pre;
      if (frighten) m_rem = FR;
      else if (frame_start && m_rem > 0) m_rem = m_rem - 1;
      m_fa = (m_rem != 0);
    end
    check("model_rom_addr", 32'(rom_addr), m_addr);
    check("model_ghost_on", 32'(ghost_on), int'(m_on));
    check("model_ghost_color", 32'(ghost_color), m_color);
    check("model_fright_active", 32'(fright_active), int'(m_fa));
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic pulse_frighten();
    frighten = 1'b1;
    tick();
    frighten = 1'b0;
    tick();
  endtask

  task automatic sweep(input logic [9:0] y, output int cnt);
    DrawY = y;
    DrawX = 10'd95;
    tick();
    tick();
    cnt = 0;
    for (int x = 95; x <= 135; x++) begin
      DrawX = 10'(x);
      tick();
      if (ghost_on === 1'b1) cnt++;
    end
    DrawX = 10'd200;
    tick();
    if (ghost_on === 1'b1) cnt++;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 32; i++) rom_mem[i] = $urandom;
    rom_ovr_en = 1'b1; rom_ovr = 32'h0;
    frame_start = 1'b0;
    DrawX = '0; DrawY = '0; GhostX = 10'd100; GhostY = 10'd50;

    // Reset held with frighten asserted: everything stays cleared
    Reset = 1'b1; frighten = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_ghost_on", 32'(ghost_on), 0);
      check("reset_ghost_color", 32'(ghost_color), 0);
      check("reset_fright_active", 32'(fright_active), 0);
    end
    Reset = 1'b0; frighten = 1'b0;

    tbl[0] = '{10'd100, 10'd50, 10'd104, 10'd62, 32'h0F87F0F0, 8'd12, 1'b1};
    tbl[1] = '{10'd100, 10'd50, 10'd110, 10'd62, 32'h0F87F0F0, 8'd12, 1'b0};
    tbl[2] = '{10'd100, 10'd50, 10'd99,  10'd62, 32'hFFFFFFFF, 8'd12, 1'b0};
    tbl[3] = '{10'd100, 10'd50, 10'd100, 10'd62, 32'hFFFFFFFF, 8'd12, 1'b1};
    tbl[4] = '{10'd100, 10'd50, 10'd131, 10'd62, 32'hFFFFFFFF, 8'd12, 1'b1};
    tbl[5] = '{10'd100, 10'd50, 10'd132, 10'd62, 32'hFFFFFFFF, 8'd12, 1'b0};
    tbl[6] = '{10'd100, 10'd50, 10'd110, 10'd49, 32'hFFFFFFFF, 8'd31, 1'b0};
    tbl[7] = '{10'd100, 10'd50, 10'd110, 10'd82, 32'hFFFFFFFF, 8'd0,  1'b0};
    tbl[8] = '{10'd100, 10'd50, 10'd110, 10'd81, 32'hFFFFFFFF, 8'd31, 1'b1};
    tbl[9] = '{10'd620, 10'd50, 10'd639, 10'd50, 32'h00000001, 8'd0,  1'b0};

    foreach (tbl[i]) begin
      rom_ovr = tbl[i].rom;
      GhostX = tbl[i].gx; GhostY = tbl[i].gy;
      DrawX  = tbl[i].dx; DrawY  = tbl[i].dy;
      tick();
      check($sformatf("tbl%0d_rom_addr", i), 32'(rom_addr), int'(tbl[i].addr));
      tick();
      check($sformatf("tbl%0d_ghost_on", i), 32'(ghost_on), int'(tbl[i].on));
    end

    // Horizontal bounds sweep with a solid sprite
    GhostX = 10'd100; GhostY = 10'd50; rom_ovr = 32'hFFFFFFFF;
    sweep(10'd62, cnt);
    check("sweep_row62_count", 32'(cnt), 32);
    sweep(10'd49, cnt);
    check("sweep_row49_count", 32'(cnt), 0);
    sweep(10'd82, cnt);
    check("sweep_row82_count", 32'(cnt), 0);

    // Full fright timeline
    pulse_frighten();
    check("fright_start_active", 32'(fright_active), 1);
    check("fright_start_color", 32'(ghost_color), 1);
    for (int k = 1; k <= 360; k++) begin
      do_frame();
      if (k == 1 || k == 263 || k == 264 || k == 273 || k == 359)
        check($sformatf("timeline_f%0d_color", k), 32'(ghost_color), 1);
      if (k == 265 || k == 272)
        check($sformatf("timeline_f%0d_color", k), 32'(ghost_color), 2);
      if (k == 359)
        check("timeline_f359_active", 32'(fright_active), 1);
      if (k == 360) begin
        check("timeline_end_color", 32'(ghost_color), 0);
        check("timeline_end_active", 32'(fright_active), 0);
      end
    end

    // Re-trigger during blink, coincident with a frame tick
    pulse_frighten();
    for (int k = 0; k < 320; k++) do_frame();
    check("retrig_blink40_color", 32'(ghost_color), 2);
    frighten = 1'b1; frame_start = 1'b1;
    tick();
    frighten = 1'b0; frame_start = 1'b0;
    check("retrig_active", 32'(fright_active), 1);
    tick();
    check("retrig_color", 32'(ghost_color), 1);
    for (int k = 1; k <= 273; k++) begin
      do_frame();
      if (k == 272) check("retrig_f272_color", 32'(ghost_color), 2);
      if (k == 273) check("retrig_f273_color", 32'(ghost_color), 1);
    end

    // Reset in the middle of fright
    pulse_frighten();
    for (int k = 0; k < 160; k++) do_frame();
    check("midreset_pre_color", 32'(ghost_color), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midreset_active", 32'(fright_active), 0);
    tick();
    check("midreset_color", 32'(ghost_color), 0);
    for (int k = 0; k < 5; k++) do_frame();
    check("midreset_after_active", 32'(fright_active), 0);
    check("midreset_after_color", 32'(ghost_color), 0);

    // Randomized traffic against the reference model
    rom_ovr_en = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 64 == 0) begin
        GhostX = 10'($urandom_range(0, 607));
        GhostY = 10'($urandom_range(0, 447));
      end
      DrawX = 10'(int'(GhostX) + int'($urandom_range(0, 80)) - 24);
      DrawY = 10'(int'(GhostY) + int'($urandom_range(0, 60)) - 12);
      frame_start = ($urandom_range(0, 7) == 0);
      frighten    = ($urandom_range(0, 599) == 0);
      Reset       = ($urandom_range(0, 799) == 0);
      tick();
    end
    Reset = 1'b0; frighten = 1'b0; frame_start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
